// File: rtl/sal_wr_ctrl.sv
// Write-data controller: buffers AXI W beats, replays them on DFI a programmable
// latency after each scheduler write grant, and returns AXI B responses in grant order.
module sal_wr_ctrl #(
    parameter int DATA_WIDTH      = 128,
    parameter int ID_WIDTH        = 4,
    parameter int BEATS_PER_GNT   = 2,
    parameter int WDATA_DEPTH_LG2 = 3,
    parameter int WID_DEPTH_LG2   = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              dfi_wren_lat,
    input  logic                    sched_wr_gnt,
    input  logic [ID_WIDTH-1:0]     sched_id,
    output logic                    wdata_avail,
    input  logic                    axi_wvalid,
    output logic                    axi_wready,
    input  logic [DATA_WIDTH-1:0]   axi_wdata,
    input  logic [DATA_WIDTH/8-1:0] axi_wstrb,
    input  logic                    axi_wlast,
    output logic                    axi_bvalid,
    input  logic                    axi_bready,
    output logic [ID_WIDTH-1:0]     axi_bid,
    output logic [1:0]              axi_bresp,
    output logic                    dfi_wrdata_en,
    output logic [DATA_WIDTH-1:0]   dfi_wrdata,
    output logic [DATA_WIDTH/8-1:0] dfi_wrdata_mask,
    output logic                    err_sticky
);

    localparam int STRB_W  = DATA_WIDTH / 8;
    localparam int W_DEPTH = 1 << WDATA_DEPTH_LG2;
    localparam int I_DEPTH = 1 << WID_DEPTH_LG2;
    localparam int BC_W    = WDATA_DEPTH_LG2 + 1;
    localparam int DC_W    = WID_DEPTH_LG2 + 1;

    localparam logic [15:0] GNT_ONES = 16'((1 << BEATS_PER_GNT) - 1);
    localparam logic [15:0] OVL_MASK = 16'((1 << (BEATS_PER_GNT - 1)) - 1);
    localparam logic [1:0]  LAST_BEAT = 2'(BEATS_PER_GNT - 1);

    // W data FIFO (first-word fall-through)
    logic [DATA_WIDTH-1:0]    wd_mem [W_DEPTH];
    logic [STRB_W-1:0]        ws_mem [W_DEPTH];
    logic [WDATA_DEPTH_LG2:0] w_wp, w_rp;
    logic                     w_empty, w_full, w_push, w_pop;

    // ID / B-pending FIFO
    logic [ID_WIDTH-1:0]      id_mem [I_DEPTH];
    logic [WID_DEPTH_LG2:0]   i_wp, i_rp;
    logic                     i_empty, i_full, i_push, i_pop;

    logic [BC_W-1:0]          burst_cnt;
    logic [DC_W-1:0]          done_cnt;
    logic [1:0]               beat_cnt;
    logic [15:0]              sr;
    logic [4:0]               en_idx;
    logic                     burst_inc, burst_dec, last_beat, b_hs, overlap;

    assign w_empty = (w_wp == w_rp);
    assign w_full  = (w_wp[WDATA_DEPTH_LG2] != w_rp[WDATA_DEPTH_LG2]) &&
                     (w_wp[WDATA_DEPTH_LG2-1:0] == w_rp[WDATA_DEPTH_LG2-1:0]);
    assign i_empty = (i_wp == i_rp);
    assign i_full  = (i_wp[WID_DEPTH_LG2] != i_rp[WID_DEPTH_LG2]) &&
                     (i_wp[WID_DEPTH_LG2-1:0] == i_rp[WID_DEPTH_LG2-1:0]);

    assign axi_wready = ~w_full & ~rst;
    assign w_push     = axi_wvalid & axi_wready;
    assign w_pop      = dfi_wrdata_en & ~w_empty;

    assign b_hs   = axi_bvalid & axi_bready;
    assign i_push = sched_wr_gnt & ~i_full;
    assign i_pop  = b_hs & ~i_empty;

    assign burst_inc = w_push & axi_wlast;
    assign burst_dec = sched_wr_gnt & (burst_cnt != '0);
    assign overlap   = |(sr & OVL_MASK);

    // Grant bits sit at [BEATS-1:0]; tapping lat+BEATS puts the first beat lat+1 cycles out
    assign en_idx        = {1'b0, dfi_wren_lat} + 5'(BEATS_PER_GNT);
    assign dfi_wrdata_en = en_idx[4] ? 1'b0 : sr[en_idx[3:0]];
    assign last_beat     = dfi_wrdata_en && (beat_cnt == LAST_BEAT);

    assign wdata_avail     = (burst_cnt != '0);
    assign axi_bvalid      = (done_cnt != '0);
    assign axi_bid         = id_mem[i_rp[WID_DEPTH_LG2-1:0]];
    assign axi_bresp       = 2'b00;
    assign dfi_wrdata      = wd_mem[w_rp[WDATA_DEPTH_LG2-1:0]];
    assign dfi_wrdata_mask = ~ws_mem[w_rp[WDATA_DEPTH_LG2-1:0]];

    always_ff @(posedge clk) begin
        if (w_push) begin
            wd_mem[w_wp[WDATA_DEPTH_LG2-1:0]] <= axi_wdata;
            ws_mem[w_wp[WDATA_DEPTH_LG2-1:0]] <= axi_wstrb;
        end
        if (i_push) begin
            id_mem[i_wp[WID_DEPTH_LG2-1:0]] <= sched_id;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_wp       <= '0;
            w_rp       <= '0;
            i_wp       <= '0;
            i_rp       <= '0;
            burst_cnt  <= '0;
            done_cnt   <= '0;
            beat_cnt   <= '0;
            sr         <= '0;
            err_sticky <= 1'b0;
        end else begin
            if (w_push) w_wp <= w_wp + 1'b1;
            if (w_pop)  w_rp <= w_rp + 1'b1;
            if (i_push) i_wp <= i_wp + 1'b1;
            if (i_pop)  i_rp <= i_rp + 1'b1;

            case ({burst_inc, burst_dec})
                2'b10:   burst_cnt <= burst_cnt + 1'b1;
                2'b01:   burst_cnt <= burst_cnt - 1'b1;
                default: burst_cnt <= burst_cnt;
            endcase

            case ({last_beat, b_hs})
                2'b10:   done_cnt <= done_cnt + 1'b1;
                2'b01:   done_cnt <= done_cnt - 1'b1;
                default: done_cnt <= done_cnt;
            endcase

            if (last_beat)          beat_cnt <= '0;
            else if (dfi_wrdata_en) beat_cnt <= beat_cnt + 1'b1;

            sr <= {sr[14:0], 1'b0} | (sched_wr_gnt ? GNT_ONES : 16'h0);

            if ((sched_wr_gnt && (burst_cnt == '0 || i_full || overlap)) ||
                (dfi_wrdata_en && w_empty))
                err_sticky <= 1'b1;
        end
    end

endmodule
